// File: rtl/text_pkg.sv
// Shared definitions for the VGA text path: character type, control codes,
// writer FSM states and the font geometry used by the renderer.
package text_pkg;

    typedef logic [7:0] char_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } twr_state_t;

    localparam char_t CHR_BS       = 8'h08;
    localparam char_t CHR_FF       = 8'h0C;
    localparam char_t CHR_CR       = 8'h0D;
    localparam char_t CHR_PRINT_LO = 8'h20;
    localparam char_t CHR_PRINT_HI = 8'h7E;

    localparam int FONT_W = 8;
    localparam int FONT_H = 16;

endpackage

// File: rtl/text_char_decode.sv
// Classifies a character code into printable / backspace / carriage return /
// form feed. At most one output is high; anything else decodes to all zero.
module text_char_decode
    import text_pkg::*;
(
    input  char_t char_i,
    output logic  is_print_o,
    output logic  is_bs_o,
    output logic  is_cr_o,
    output logic  is_ff_o
);

    assign is_print_o = (char_i >= CHR_PRINT_LO) && (char_i <= CHR_PRINT_HI);
    assign is_bs_o    = (char_i == CHR_BS);
    assign is_cr_o    = (char_i == CHR_CR);
    assign is_ff_o    = (char_i == CHR_FF);

endmodule

// File: rtl/text_buffer_writer.sv
// Producer side of the text path: consumes a character stream, tracks the
// write cursor and keeps the flop-based text buffer read by the renderer.
module text_buffer_writer
    import text_pkg::*;
#(
    parameter int              NUM_CHARS  = 256,
    parameter int              CURSOR_W   = 8,
    parameter logic [7:0]      BLANK_CHAR = 8'h20,
    parameter bit              WRAP       = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                char_valid,
    input  logic [7:0]          char_data,
    output logic                char_ready,
    output logic [7:0]          text [NUM_CHARS-1:0],
    output logic [CURSOR_W-1:0] cursor,
    output logic                busy
);

    localparam logic [CURSOR_W-1:0] LAST_IDX = CURSOR_W'(NUM_CHARS - 1);

    // Handshake: a code transfers on a rising edge where char_valid and
    // char_ready are both high; ready depends only on state and reset.
    twr_state_t          state_q, state_d;
    logic [CURSOR_W-1:0] cursor_q, cursor_d;
    logic [CURSOR_W-1:0] clr_idx_q, clr_idx_d;
    logic                busy_q, busy_d;
    logic [7:0]          text_q [NUM_CHARS-1:0];

    logic                wr_en;
    logic [CURSOR_W-1:0] wr_idx;
    logic [7:0]          wr_data;

    logic xfer;
    logic is_print, is_bs, is_cr, is_ff;

    text_char_decode u_decode (
        .char_i     (char_data),
        .is_print_o (is_print),
        .is_bs_o    (is_bs),
        .is_cr_o    (is_cr),
        .is_ff_o    (is_ff)
    );

    assign char_ready = (state_q == IDLE) && rst_n;
    assign xfer       = char_valid && char_ready;

    // Single write port: every cycle resolves to at most one (index, data).
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        wr_en     = 1'b0;
        wr_idx    = cursor_q;
        wr_data   = char_data;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (is_print) begin
                        wr_en = 1'b1;
                        if (cursor_q != LAST_IDX) begin
                            cursor_d = cursor_q + 1'b1;
                        end else if (WRAP) begin
                            cursor_d = '0;
                        end
                    end else if (is_bs) begin
                        if (cursor_q != '0) begin
                            cursor_d = cursor_q - 1'b1;
                            wr_en    = 1'b1;
                            wr_idx   = cursor_q - 1'b1;
                            wr_data  = BLANK_CHAR;
                        end
                    end else if (is_cr) begin
                        cursor_d = '0;
                    end else if (is_ff) begin
                        cursor_d  = '0;
                        clr_idx_d = '0;
                        state_d   = CLEAR;
                        busy_d    = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_idx_q;
                wr_data   = BLANK_CHAR;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cursor_q  <= '0;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                text_q[i] <= BLANK_CHAR;
            end
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
            if (wr_en) begin
                text_q[wr_idx] <= wr_data;
            end
        end
    end

    assign text   = text_q;
    assign cursor = cursor_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: one wrapping and one saturating instance
// share a stimulus stream and are checked against an array-based model.
module tb_text_buffer_writer;
  import text_pkg::*;

  localparam int N     = 256;
  localparam int W     = 1 + 8 + 8 * N;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_data;

  logic       ready_w, busy_w, ready_s, busy_s;
  logic [7:0] cursor_w, cursor_s;
  logic [7:0] text_w [N-1:0];
  logic [7:0] text_s [N-1:0];

  text_buffer_writer #(.NUM_CHARS(N), .CURSOR_W(8), .BLANK_CHAR(BLANK), .WRAP(1'b1)) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (ready_w),
    .text       (text_w),
    .cursor     (cursor_w),
    .busy       (busy_w)
  );

  text_buffer_writer #(.NUM_CHARS(N), .CURSOR_W(8), .BLANK_CHAR(BLANK), .WRAP(1'b0)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (ready_s),
    .text       (text_s),
    .cursor     (cursor_s),
    .busy       (busy_s)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain arrays and counters, k=0 wraps, k=1 saturates
  logic [7:0] m_text [2][N];
  int         m_cur [2];
  int         clr_left = 0;
  int         clr_idx  = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always @(posedge clk) begin
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) m_text[k][i] = BLANK;
        m_cur[k] = 0;
      end
      clr_left = 0;
      clr_idx  = 0;
    end else if (clr_left > 0) begin
      m_text[0][clr_idx] = BLANK;
      m_text[1][clr_idx] = BLANK;
      clr_idx  = clr_idx + 1;
      clr_left = clr_left - 1;
    end else if (char_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (char_data >= 8'h20 && char_data <= 8'h7E) begin
          m_text[k][m_cur[k]] = char_data;
          if (m_cur[k] < N - 1) m_cur[k] = m_cur[k] + 1;
          else if (k == 0) m_cur[k] = 0;
        end else if (char_data == 8'h08) begin
          if (m_cur[k] > 0) begin
            m_cur[k] = m_cur[k] - 1;
            m_text[k][m_cur[k]] = BLANK;
          end
        end else if (char_data == 8'h0D) begin
          m_cur[k] = 0;
        end else if (char_data == 8'h0C) begin
          m_cur[k] = 0;
        end
      end
      if (char_data == 8'h0C) begin
        clr_idx  = 0;
        clr_left = N;
      end
    end
    s0[W-1]     = (clr_left > 0);
    s1[W-1]     = (clr_left > 0);
    s0[W-2 -: 8] = m_cur[0][7:0];
    s1[W-2 -: 8] = m_cur[1][7:0];
    for (int i = 0; i < N; i++) begin
      s0[i*8 +: 8] = m_text[0][i];
      s1[i*8 +: 8] = m_text[1][i];
    end
    exp_q0.push_back(s0);
    exp_q1.push_back(s1);
  end

  task automatic check(input string nm, input logic [W-1:0] e, input logic rdy,
                       input logic bsy, input logic [7:0] cur, input logic [8*N-1:0] txt);
    logic exp_busy;
    logic exp_rdy;
    exp_busy = e[W-1];
    exp_rdy  = !exp_busy && rst_n;
    n_checks++;
    if (rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s char_ready at %0t: got %b expected %b", nm, $time, rdy, exp_rdy);
    end
    n_checks++;
    if (bsy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s busy at %0t: got %b expected %b", nm, $time, bsy, exp_busy);
    end
    n_checks++;
    if (cur !== e[W-2 -: 8]) begin
      n_fail++;
      $display("FAIL %s cursor at %0t: got %0d expected %0d", nm, $time, cur, e[W-2 -: 8]);
    end
    n_checks++;
    if (txt !== e[8*N-1:0]) begin
      n_fail++;
      for (int i = 0; i < N; i++) begin
        if (txt[i*8 +: 8] !== e[i*8 +: 8]) begin
          $display("FAIL %s text[%0d] at %0t: got %h expected %h", nm, i, $time,
                   txt[i*8 +: 8], e[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  // monitor
  int   busy_run   = 0;
  logic run_reset  = 1'b0;

  always @(negedge clk) begin
    logic [8*N-1:0] fw;
    logic [8*N-1:0] fs;
    for (int i = 0; i < N; i++) begin
      fw[i*8 +: 8] = text_w[i];
      fs[i*8 +: 8] = text_s[i];
    end
    if (exp_q0.size() > 0) check("wrap", exp_q0.pop_front(), ready_w, busy_w, cursor_w, fw);
    if (exp_q1.size() > 0) check("sat", exp_q1.pop_front(), ready_s, busy_s, cursor_s, fs);
    if (busy_w === 1'b1) begin
      busy_run++;
      if (!rst_n) run_reset = 1'b1;
    end else begin
      if (busy_run > 0 && !run_reset && rst_n) begin
        n_checks++;
        if (busy_run != N) begin
          n_fail++;
          $display("FAIL clear_length: got %0d cycles expected %0d", busy_run, N);
        end
      end
      busy_run  = 0;
      run_reset = !rst_n;
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d);
    int   t;
    logic r;
    t = 0;
    char_valid = 1'b1;
    char_data  = d;
    do begin
      @(negedge clk);
      r = ready_w;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 1000);
    if (!r) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no ready within %0d cycles expected ready", t);
    end
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    char_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(8'h48);
    send(8'h49);
    idle(2);

    send(8'h08);
    send(8'h08);
    send(8'h08);
    idle(1);

    send(8'h0D);
    for (int i = 0; i < N; i++) send(8'h41);
    send(8'h42);
    idle(2);

    send(8'h0C);
    send(8'h5A);
    idle(3);

    for (int i = 0; i < 10; i++) send(8'h61 + 8'(i));
    send(8'h0C);
    idle(100);
    do_reset();
    idle(2);

    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    send(8'h0D);
    send(8'h07);
    send(8'h41);
    idle(2);

    for (int n = 0; n < 500; n++) begin
      idle($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 80)      send(8'($urandom_range(32, 126)));
      else if (r < 88) send(8'h08);
      else if (r < 93) send(8'h0D);
      else if (r < 95) send(8'h0C);
      else             send(8'($urandom_range(0, 255)));
    end
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Producer side of the VGA text path: accepts a byte stream of character codes from the CPU/IO bus and maintains the 256-entry text buffer consumed by the pixel renderer.
- Holds a write cursor and interprets a small set of control codes: backspace, carriage return and form-feed clear.
- Output array is flop-based and always readable, so the renderer samples it every pixel clock with no arbitration.

Parameters:
- NUM_CHARS, 256, number of character cells; must be a power of two.
- CURSOR_W, 8, cursor width, equal to log2(NUM_CHARS).
- BLANK_CHAR, 8'h20, code written by clear and backspace.
- WRAP, 1, 1 = cursor wraps NUM_CHARS-1 -> 0; 0 = cursor saturates at NUM_CHARS-1.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  synchronous active-low reset.
- char_valid  in  1  char_data is presented.
- char_data  in  8  character or control code.
- char_ready  out  1  writer can accept a code this cycle.
- text  out  8 x NUM_CHARS  text buffer, unpacked array [NUM_CHARS-1:0] of 8-bit entries.
- cursor  out  CURSOR_W  index of the next cell to be written.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All text entries = BLANK_CHAR, cursor = 0, FSM = IDLE, busy = 0, char_ready = 0 during the reset cycle.
  - Reset asserted mid-CLEAR aborts the sequence; the reset values above apply.
- Handshake:
  - Transfer occurs when char_valid && char_ready at posedge clk.
  - char_ready = (state==IDLE) && rst_n. It is combinational from state only, never from char_valid.
  - char_data is sampled only on a transfer.
- FSM states: IDLE, CLEAR.
- IDLE, on transfer, decode char_data. Buffer and cursor updates are visible the cycle after the accepting edge (latency 1).
  - 8'h20..8'h7E (printable): text[cursor] <= char_data.
    - If cursor != NUM_CHARS-1: cursor <= cursor+1.
    - If cursor == NUM_CHARS-1: WRAP=1 gives cursor <= 0; WRAP=0 holds cursor, so later writes overwrite the last cell.
  - 8'h08 (backspace):
    - If cursor > 0: cursor <= cursor-1 and text[cursor-1] <= BLANK_CHAR.
    - If cursor == 0: no change, code still consumed.
  - 8'h0D (carriage return): cursor <= 0, buffer unchanged.
  - 8'h0C (form feed): cursor <= 0, clear index <= 0, state <= CLEAR.
  - Any other code: consumed, no effect.
- CLEAR:
  - Each cycle: text[clr_idx] <= BLANK_CHAR, clr_idx <= clr_idx+1.
  - After writing index NUM_CHARS-1, return to IDLE.
  - Duration is exactly NUM_CHARS cycles. busy = 1 and char_ready = 0 for all of them.
  - char_ready rises in the cycle after the last blank is written.
- Only one buffer write per cycle, at one index.
- Arithmetic: cursor and clr_idx are CURSOR_W-bit unsigned. Wrap is natural modulo 2^CURSOR_W when WRAP=1; explicit compare otherwise.
- char_valid held high while char_ready=0: no transfer, no state change, data not latched.

Decomposition:
- Package text_pkg:
  - Control-code constants CHR_BS=8'h08, CHR_FF=8'h0C, CHR_CR=8'h0D.
  - Printable range bounds CHR_PRINT_LO=8'h20, CHR_PRINT_HI=8'h7E.
  - typedef enum logic {IDLE, CLEAR} twr_state_t.
  - typedef logic [7:0] char_t.
- Shared with the renderer: text_pkg, and the font parameters (8x16).
- One sub-module is natural: text_char_decode.
  - Combinational.
  - Input: char_t. Outputs: one-hot is_print, is_bs, is_cr, is_ff.

Test Plan:
- Reset then send 'H','I' (8'h48, 8'h49) back-to-back with char_valid=1 -> text[0]=8'h48, text[1]=8'h49, cursor=2, char_ready stays 1, each write visible one cycle after acceptance.
- Cursor=2 after 'H','I'; send 8'h08 twice then a third 8'h08 -> text[1]=8'h20, then text[0]=8'h20, cursor reaches 0; third backspace leaves cursor=0 and buffer unchanged.
- Fill 256 printable chars 'A' (8'h41), then send 'B' (8'h42):
  - WRAP=1 -> text[0]=8'h42, cursor=1.
  - WRAP=0 -> text[255]=8'h42, cursor=255.
- Fill buffer, send 8'h0C with char_valid held high and next byte 'Z' (8'h5A):
  - busy=1 and char_ready=0 for exactly 256 cycles; all entries become 8'h20, cursor=0.
  - 'Z' is accepted only afterwards and lands in text[0].
- Assert rst_n=0 at clear index 100 -> next cycle all entries 8'h20, cursor=0, busy=0; char_ready=1 the cycle after rst_n returns high.
- Send 8'h0D after 5 chars, then 8'h07 and 8'h41 -> 8'h0D gives cursor=0 with buffer intact; 8'h07 is consumed with no change; 8'h41 lands in text[0], cursor=1.
